// File: rtl/merge_router_pkt.sv
// Packet-aware N-port merge router: per-input FWFT FIFOs joined in lockstep,
// heads forwarded from the lowest masked port, body/tail payloads summed with saturation.
module merge_router_pkt #(
  parameter int NP    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NP-1:0]     cfg_mask,
  input  logic [NP-1:0]     cfg_sel,
  input  logic [NP*DW-1:0]  data_i,
  input  logic [NP-1:0]     valid_i,
  output logic [NP-1:0]     ready_o,
  output logic [DW-1:0]     data_o,
  output logic [NP-1:0]     valid_o,
  input  logic [NP-1:0]     ready_i,
  output logic              err_o,
  output logic [15:0]       pkt_cnt_o
);

  localparam int PW = DW - 2;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = PW + $clog2(NP) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BODY = 1'b1;

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b10;

  localparam logic [PW-1:0] PMAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] PMIN = {1'b1, {(PW-1){1'b0}}};
  localparam logic [SW-1:0] SMAX = {{(SW-PW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic [SW-1:0] SMIN = {{(SW-PW+1){1'b1}}, {(PW-1){1'b0}}};
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  function automatic logic [SW-1:0] sext(input logic [PW-1:0] p);
    return {{(SW-PW){p[PW-1]}}, p};
  endfunction

  logic [DW-1:0] mem    [NP][DEPTH];
  logic [AW-1:0] wr_ptr [NP];
  logic [AW-1:0] rd_ptr [NP];
  logic [AW:0]   count  [NP];
  logic [DW-1:0] head   [NP];
  logic [NP-1:0] wr_en;
  logic [NP-1:0] rd_en;
  logic [NP-1:0] not_empty;

  logic [0:0]    state;
  logic [NP-1:0] m;
  logic [NP-1:0] s;
  logic          out_full;

  logic          all_head;
  logic          all_body;
  logic          all_tail;
  logic          join_ready;
  logic          out_hs;
  logic          out_accept;
  logic          fire;
  logic          emit_head;
  logic          emit_body;
  logic          emit_tail;
  logic          emit;
  logic          proto_err;
  logic [SW-1:0] sum;
  logic [PW-1:0] sat;
  logic [DW-1:0] first_head;
  logic [DW-1:0] merged;

  // FIFO status, head-of-queue view and push/pop strobes
  always_comb begin
    for (int k = 0; k < NP; k++) begin
      not_empty[k] = (count[k] != {(AW+1){1'b0}});
      ready_o[k]   = (count[k] != FULL_CNT);
      head[k]      = mem[k][rd_ptr[k]];
      wr_en[k]     = valid_i[k] & ready_o[k];
      rd_en[k]     = fire & m[k];
    end
  end

  // Type agreement, join readiness and payload sum across masked inputs
  always_comb begin
    all_head   = 1'b1;
    all_body   = 1'b1;
    all_tail   = 1'b1;
    join_ready = |m;
    sum        = {SW{1'b0}};
    first_head = {DW{1'b0}};
    // Descending scan so the lowest masked index ends up in first_head
    for (int k = NP - 1; k >= 0; k--) begin
      all_head   = all_head & (~m[k] | (head[k][DW-1:DW-2] == T_HEAD));
      all_body   = all_body & (~m[k] | (head[k][DW-1:DW-2] == T_BODY));
      all_tail   = all_tail & (~m[k] | (head[k][DW-1:DW-2] == T_TAIL));
      join_ready = join_ready & (~m[k] | not_empty[k]);
      sum        = sum + (m[k] ? sext(head[k][PW-1:0]) : {SW{1'b0}});
      first_head = m[k] ? head[k] : first_head;
    end
  end

  // Saturation and outgoing flit selection
  always_comb begin
    if ($signed(sum) > $signed(SMAX)) begin
      sat = PMAX;
    end else if ($signed(sum) < $signed(SMIN)) begin
      sat = PMIN;
    end else begin
      sat = sum[PW-1:0];
    end
    if (emit_head) begin
      merged = first_head;
    end else if (emit_tail) begin
      merged = {T_TAIL, sat};
    end else begin
      merged = {T_BODY, sat};
    end
  end

  assign out_hs     = out_full & (|(ready_i & s));
  assign out_accept = ~out_full | (|(ready_i & s));
  assign fire       = join_ready & out_accept;
  assign emit_head  = fire & (state == IDLE) & all_head;
  assign emit_body  = fire & (state == BODY) & all_body;
  assign emit_tail  = fire & (state == BODY) & all_tail;
  assign emit       = emit_head | emit_body | emit_tail;
  assign proto_err  = fire & ~emit;
  assign valid_o    = {NP{out_full}} & s;

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NP; k++) begin
        wr_ptr[k] <= {AW{1'b0}};
        rd_ptr[k] <= {AW{1'b0}};
        count[k]  <= {(AW+1){1'b0}};
      end
    end else begin
      for (int k = 0; k < NP; k++) begin
        if (wr_en[k]) wr_ptr[k] <= wr_ptr[k] + {{(AW-1){1'b0}}, 1'b1};
        if (rd_en[k]) rd_ptr[k] <= rd_ptr[k] + {{(AW-1){1'b0}}, 1'b1};
        count[k] <= count[k] + {{AW{1'b0}}, wr_en[k]} - {{AW{1'b0}}, rd_en[k]};
      end
    end
  end

  // FIFO storage, no reset needed since occupancy gates visibility
  always_ff @(posedge clk) begin
    for (int k = 0; k < NP; k++) begin
      if (wr_en[k]) mem[k][wr_ptr[k]] <= data_i[k*DW +: DW];
    end
  end

  // Packet FSM, config latch, output register and status counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      m         <= {NP{1'b0}};
      s         <= {NP{1'b0}};
      out_full  <= 1'b0;
      data_o    <= {DW{1'b0}};
      err_o     <= 1'b0;
      pkt_cnt_o <= 16'd0;
    end else begin
      if (emit_head) begin
        state <= BODY;
      end else if (emit_tail | proto_err) begin
        state <= IDLE;
      end
      // Config keeps tracking in IDLE but is held from the accepted head onward
      if ((state == IDLE) && !emit_head) begin
        m <= cfg_mask;
        s <= cfg_sel;
      end
      if (emit) begin
        out_full <= 1'b1;
        data_o   <= merged;
      end else if (out_hs) begin
        out_full <= 1'b0;
      end
      if (proto_err) err_o <= 1'b1;
      if (emit_tail) pkt_cnt_o <= pkt_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_merge_router_pkt.sv
// Randomized bench for merge_router_pkt: per-port flit streams are joined by a
// queue-based reference model and the output stream is scoreboarded.
module tb_merge_router_pkt;

  localparam int NP    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int PW    = DW - 2;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     cfg_mask;
  logic [NP-1:0]     cfg_sel;
  logic [NP*DW-1:0]  data_i;
  logic [NP-1:0]     valid_i;
  logic [NP-1:0]     ready_o;
  logic [DW-1:0]     data_o;
  logic [NP-1:0]     valid_o;
  logic [NP-1:0]     ready_i;
  logic              err_o;
  logic [15:0]       pkt_cnt_o;

  merge_router_pkt #(.NP(NP), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_mask(cfg_mask), .cfg_sel(cfg_sel),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .err_o(err_o), .pkt_cnt_o(pkt_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] inq [NP][$];
  logic [DW-1:0] exp_q [$];
  bit            m_busy;
  logic [NP-1:0] m_mask;
  logic          m_err;
  logic [15:0]   m_cnt;
  logic [NP-1:0] acc_last;
  logic [DW-1:0] beat [NP];
  int            bp_mode;
  logic [NP-1:0] bp_val;
  int            cyc;
  int            bp_check_at;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int v);
    logic [31:0] w;
    w = v;
    return {t, w[PW-1:0]};
  endfunction

  // Reference: consume one flit per masked port in order and apply the packet rules
  task automatic model_run();
    logic [NP-1:0] msk;
    logic [DW-1:0] f;
    logic [DW-1:0] first;
    longint        sum;
    longint        lim;
    logic [63:0]   sv;
    int            nh, nb, nt, nm;
    bit            ok, found;
    lim = 64'sd1 <<< (PW - 1);
    while (1) begin
      msk = m_busy ? m_mask : cfg_mask;
      if (msk == '0) break;
      ok = 1;
      for (int k = 0; k < NP; k++) if (msk[k] && inq[k].size() == 0) ok = 0;
      if (!ok) break;
      nh = 0; nb = 0; nt = 0; nm = 0; sum = 0; found = 0; first = '0;
      for (int k = 0; k < NP; k++) begin
        if (msk[k]) begin
          f = inq[k].pop_front();
          nm++;
          if (f[DW-1:DW-2] == 2'b01) nh++;
          if (f[DW-1:DW-2] == 2'b00) nb++;
          if (f[DW-1:DW-2] == 2'b10) nt++;
          if (!found) first = f;
          found = 1;
          sum = sum + longint'($signed(f[PW-1:0]));
        end
      end
      if (sum > lim - 1) sum = lim - 1;
      if (sum < -lim) sum = -lim;
      sv = sum;
      if (!m_busy && nh == nm) begin
        exp_q.push_back(first);
        m_busy = 1;
        m_mask = msk;
      end else if (m_busy && nb == nm) begin
        exp_q.push_back({2'b00, sv[PW-1:0]});
      end else if (m_busy && nt == nm) begin
        exp_q.push_back({2'b10, sv[PW-1:0]});
        m_cnt = m_cnt + 16'd1;
        m_busy = 0;
      end else begin
        m_err = 1;
        m_busy = 0;
      end
    end
  endtask

  task automatic monitor();
    if (rst) begin
      for (int k = 0; k < NP; k++) inq[k].delete();
      exp_q.delete();
      m_busy = 0; m_mask = '0; m_err = 0; m_cnt = '0; acc_last = '0;
    end else begin
      acc_last = valid_i & ready_o;
      for (int k = 0; k < NP; k++) if (acc_last[k]) inq[k].push_back(data_i[k*DW +: DW]);
      model_run();
      if ((valid_o & ready_i) != '0) begin
        check_eq("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("out_data", data_o, exp_q.pop_front());
      end
      if (valid_o != '0) check_eq("valid_sel", 32'(valid_o & ~cfg_sel), 32'd0);
    end
  endtask

  // One clock: observe at negedge, then drive downstream ready after the posedge
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (cyc == bp_check_at) begin
      check_eq("bp_ready_low", 32'(ready_o & 5'b00111), 32'd0);
      check_eq("bp_out_held", 32'(valid_o), 32'd1);
      bp_val = '1;
    end
    case (bp_mode)
      0:       ready_i = '1;
      1:       ready_i = NP'($urandom);
      default: ready_i = bp_val;
    endcase
  endtask

  task automatic send_beat(input logic [NP-1:0] ports);
    int n;
    n = 0;
    for (int k = 0; k < NP; k++) if (ports[k]) data_i[k*DW +: DW] = beat[k];
    valid_i = ports;
    while (valid_i != '0 && n < 400) begin
      tick();
      valid_i = valid_i & ~acc_last;
      n++;
    end
    check_eq("beat_accepted", 32'(valid_i), 32'd0);
    valid_i = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_o != '0) && n < 600) begin
      tick();
      n++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_cnt"}, 32'(pkt_cnt_o), 32'(m_cnt));
    check_eq({tag, "_err"}, 32'(err_o), 32'(m_err));
  endtask

  function automatic int rand_pl();
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 100)) - 50;
      1:       return int'($urandom);
      default: return ($urandom_range(0, 1) != 0) ? 32'h1FFFFFF0 : 32'h20000010;
    endcase
  endfunction

  task automatic rand_beat(input logic [1:0] t, input logic [NP-1:0] ports);
    for (int k = 0; k < NP; k++) beat[k] = mk(t, rand_pl());
    send_beat(ports);
  endtask

  task automatic fill3(input logic [1:0] t, input int a, input int b, input int c);
    beat[0] = mk(t, a); beat[1] = mk(t, b); beat[2] = mk(t, c);
    send_beat(5'b00111);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NP-1:0] msk;
    rst = 1'b1; valid_i = '0; data_i = '0; cfg_mask = '0; cfg_sel = '0;
    ready_i = '1; bp_mode = 0; bp_val = '1; cyc = 0; bp_check_at = -1;
    m_busy = 0; m_mask = '0; m_err = 0; m_cnt = '0; acc_last = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_ready", 32'(ready_o), 32'h1F);
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_data", data_o, 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_cnt", 32'(pkt_cnt_o), 32'd0);

    // Basic packet plus two-cycle latency
    cfg_mask = 5'b00111; cfg_sel = 5'b00001;
    repeat (3) tick();
    fill3(2'b01, 32'h111, 32'h222, 32'h333);
    check_eq("lat_t1", 32'(valid_o), 32'd0);
    tick();
    check_eq("lat_t2", 32'(valid_o), 32'd1);
    fill3(2'b00, 3, -1, 10);
    fill3(2'b10, 1, 1, 1);
    drain();
    check_eq("pkt_cnt_first", 32'(pkt_cnt_o), 32'd1);
    check_status("basic");

    // Saturation both ways
    fill3(2'b01, 0, 0, 0);
    fill3(2'b00, 32'h1FFFFFFF, 32'h1FFFFFFF, 32'h1FFFFFFF);
    fill3(2'b00, 32'h20000000, 32'h20000000, 32'h20000000);
    fill3(2'b10, 32'h1FFFFFFF, 5, -7);
    drain();
    check_status("sat");

    // Random packets with random mask, select and downstream stalls
    bp_mode = 1;
    for (int p = 0; p < 10; p++) begin
      msk = NP'($urandom_range(1, 31));
      cfg_mask = msk;
      cfg_sel = NP'(1) << $urandom_range(0, NP - 1);
      repeat (3) tick();
      rand_beat(2'b01, msk);
      for (int b = 0, nb = $urandom_range(0, 4); b < nb; b++) rand_beat(2'b00, msk);
      rand_beat(2'b10, msk);
      bp_mode = 0;
      drain();
      bp_mode = 1;
      check_status("rand");
    end
    bp_mode = 0;
    cfg_mask = 5'b00111; cfg_sel = 5'b00001;
    repeat (3) tick();

    // Long stall: FIFOs fill to depth, then drain without loss
    bp_mode = 2; bp_val = '1;
    fill3(2'b01, 7, 8, 9);
    drain();
    bp_val = 5'b11110;
    tick();
    bp_check_at = cyc + 20;
    for (int i = 0; i < 12; i++) fill3(2'b00, i, -2 * i, 100 + i);
    fill3(2'b10, 2, 3, 4);
    bp_mode = 0;
    drain();
    check_status("bp");

    // Protocol error mid-packet, then a clean packet
    fill3(2'b01, 1, 2, 3);
    fill3(2'b00, 4, 5, 6);
    beat[0] = mk(2'b00, 1); beat[1] = mk(2'b01, 2); beat[2] = mk(2'b00, 3);
    send_beat(5'b00111);
    drain();
    check_eq("err_set", 32'(err_o), 32'd1);
    fill3(2'b01, 9, 9, 9);
    fill3(2'b00, -5, -6, 20);
    fill3(2'b10, 0, 0, -1);
    drain();
    check_status("after_err");

    // Mask change inside a packet is held off until the tail
    fill3(2'b01, 11, 12, 13);
    fill3(2'b00, 1, 2, 3);
    cfg_mask = 5'b00011;
    repeat (5) tick();
    fill3(2'b00, 10, 20, 30);
    fill3(2'b10, 5, 5, 5);
    drain();
    repeat (2) tick();
    beat[0] = mk(2'b01, 44); beat[1] = mk(2'b01, 55); send_beat(5'b00011);
    beat[0] = mk(2'b00, 40); beat[1] = mk(2'b00, -41); send_beat(5'b00011);
    beat[0] = mk(2'b10, 6); beat[1] = mk(2'b10, 7); send_beat(5'b00011);
    drain();
    check_status("freeze");

    // Empty mask: nothing joins, port 0 just fills up
    cfg_mask = '0;
    repeat (3) tick();
    for (int i = 0; i < DEPTH; i++) begin
      beat[0] = mk(2'b01, i);
      send_beat(5'b00001);
    end
    repeat (10) tick();
    check_eq("m0_no_out", 32'(valid_o), 32'd0);
    check_eq("m0_no_pop", 32'(ready_o[0]), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg_mask = 5'b00111; cfg_sel = 5'b00001;
    repeat (3) tick();

    // Asynchronous reset with a body flit waiting in the output register
    fill3(2'b01, 1, 1, 1);
    fill3(2'b00, 2, 2, 2);
    drain();
    bp_mode = 2; bp_val = 5'b11110;
    fill3(2'b00, 5, 6, 7);
    repeat (3) tick();
    check_eq("pre_rst_valid", 32'(valid_o), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(valid_o), 32'd0);
    check_eq("arst_data", data_o, 32'd0);
    check_eq("arst_ready", 32'(ready_o), 32'h1F);
    check_eq("arst_cnt", 32'(pkt_cnt_o), 32'd0);
    check_eq("arst_err", 32'(err_o), 32'd0);
    tick();
    rst = 1'b0;
    bp_mode = 0;
    repeat (3) tick();
    fill3(2'b01, 21, 22, 23);
    fill3(2'b00, -100, 50, 49);
    fill3(2'b10, 8, 8, 8);
    drain();
    check_eq("post_rst_cnt", 32'(pkt_cnt_o), 32'd1);
    check_status("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/merge_router_pkt.md
Name: merge_router_pkt

Overview:
- Parametrised, packet-aware successor of the fixed 5-port merge router.
- N input ports, each with its own FWFT input FIFO. Flits from all masked inputs are joined in lockstep.
- Head flits: one representative head is forwarded. Body/tail flits: payloads are summed as saturating signed integers.
- Mask and output port are runtime configuration, frozen per packet. Sits at reduction points of the mesh NoC.

Parameters:
- NP, 5, number of ports (index 0 = local, then W/E/N/S for the mesh case).
- DW, 32, flit width; bits [DW-1:DW-2] = flit type, bits [DW-3:0] = signed payload (PW = DW-2).
- DEPTH, 8, per-input FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_mask  in  NP  inputs participating in the merge.
- cfg_sel  in  NP  one-hot output port select.
- data_i  in  NP*DW  input flits; port k occupies [k*DW +: DW].
- valid_i  in  NP  input valid.
- ready_o  out  NP  input ready = FIFO not full.
- data_o  out  DW  merged flit, shared by all output ports.
- valid_o  out  NP  output valid; only the bit selected by the frozen cfg_sel can be 1.
- ready_i  in  NP  downstream ready.
- err_o  out  1  sticky protocol error.
- pkt_cnt_o  out  16  packets completed (tail flits emitted), wraps at 2^16.

Behaviour:
Flit types:
- 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 reserved (always an error).

Input FIFOs:
- Write when valid_i[k] & ready_o[k].
- FWFT: the head entry is visible the cycle after its write edge.
- Full at DEPTH entries.
- Simultaneous read and write when full is not allowed (ready_o is low). When not full, simultaneous read and write is allowed.

Configuration latch:
- m (mask) and s (select) load from cfg_mask/cfg_sel every cycle while the FSM is in IDLE.
- They are frozen in BODY.

Join:
- The join is ready when m ≠ 0 and every FIFO k with m[k]=1 is non-empty.
- The join fires when it is ready and the output register can accept a flit.
- The output register can accept when it is empty, or when ready_i of the port selected by s is 1 in that cycle.
- On fire, every masked FIFO is popped in the same cycle.
- Unmasked FIFOs are never popped; their data accumulates until full.

FSM states: IDLE, BODY.
- IDLE, all masked flits HEAD: emit the head of the lowest-index masked input unchanged; go to BODY.
- BODY, all masked flits BODY: emit {2'b00, sum}; stay in BODY.
- BODY, all masked flits TAIL: emit {2'b10, sum}; increment pkt_cnt_o; go to IDLE.
- Any other type combination (mixed types, HEAD in BODY, BODY/TAIL in IDLE, reserved type 11): pop all masked FIFOs, emit nothing, set err_o, go to IDLE.

Sum arithmetic:
- Masked payloads are sign-extended to PW+$clog2(NP)+1 bits and added.
- The result saturates to [-2^(PW-1), 2^(PW-1)-1].

Output register:
- One stage. valid_o[j] = full & s[j].
- It is cleared by a handshake on the selected port unless a new fire reloads it in the same cycle.
- Back-to-back throughput is 1 flit per cycle.

Latency:
- With all masked inputs arriving at edge t and no backpressure, valid_o is high after edge t+2.

Reset:
- Asynchronous: FIFOs empty, output register empty, FSM in IDLE, m and s cleared.
- err_o = 0, pkt_cnt_o = 0, valid_o = 0, data_o = 0.
- ready_o is all 1 after reset.
- A reset during a packet discards the partial packet; no tail is emitted.

Other boundary rules:
- m = 0: the join never fires.
- s not one-hot: the emitted flit is presented on every port selected by s, and it advances when any selected port is ready.
- cfg changes while in BODY are ignored until IDLE.

Test Plan:
- NP=5, m=5'b00111, s=local. Each input sends HEAD, BODY 3/-1/10, TAIL 1/1/1 → output: HEAD from port0, BODY payload 12, TAIL payload 3; pkt_cnt_o=1; first valid_o[0] two cycles after the input edge.
- Saturation, PW=30, 3 inputs each BODY 0x1FFFFFFF → payload 0x1FFFFFFF. Same inputs with 0x20000000 → 0x20000000 (most negative); err_o stays 0.
- Backpressure: ready_i[sel]=0 for 20 cycles during a BODY stream → each masked FIFO fills to 8 and ready_o drops. On release, 8+1 flits drain at 1 per cycle with correct sums and no loss or duplication.
- Protocol error: in BODY, port0 sends BODY while port1 sends HEAD → both popped, nothing emitted, err_o=1 sticky, FSM in IDLE. The next correct packet still merges properly.
- Config freeze: change cfg_mask mid-packet → ignored until the TAIL is emitted; the new mask applies to the next HEAD. m=0 → no output and no pops.
- Async reset mid-packet: assert rst between two BODY flits → all outputs 0 immediately, FIFOs empty. A fresh packet after deassert merges correctly with pkt_cnt_o starting from 0.
